// File: rtl/fifo_word_packer_pkg.sv
// rtl/fifo_word_packer_pkg.sv - shared types and sizing helpers for fifo_word_packer
//
// Purpose: FSM state type and the lane-counter width rule used by the packer.
// Ports: none (package).

package fifo_word_packer_pkg;

  typedef enum logic {FILL, HOLD} packer_state_t;

  // Lane counter width: $clog2(ratio), but never narrower than one bit.
  function automatic int count_width(input int ratio);
    return (ratio <= 2) ? 1 : $clog2(ratio);
  endfunction

endpackage

// File: rtl/fifo_word_packer.sv
// rtl/fifo_word_packer.sv - packs RATIO consecutive FIFO words into one wide output word
//
// Purpose: sits behind a syncFIFO, pops narrow words, assembles them lane by
// lane (first popped word in the lowest lane) and offers the wide word on a
// valid/ready port. Handles registered and fall-through FIFO read timing.
// Optional build macro: FIFO_WORD_PACKER_FLUSH_EN (adds flush / out_count).
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-low reset
//   fifo_en    FIFO enable, high only on pop cycles
//   fifo_rw    FIFO direction, always read (0)
//   fifo_out   FIFO read data
//   fifo_empty FIFO empty flag
//   out_data   packed word, lane 0 in the low bits
//   out_valid  out_data holds a complete word
//   out_ready  downstream accepts out_data
//   flush      (macro only) emit the current partial word
//   out_count  (macro only) number of valid lanes in out_data

module fifo_word_packer
  import fifo_word_packer_pkg::*;
#(
  parameter int DATA_WIDTH   = 4,
  parameter int RATIO        = 4,
  parameter int FALL_THROUGH = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic                          fifo_en,
  output logic                          fifo_rw,
  input  logic [DATA_WIDTH-1:0]         fifo_out,
  input  logic                          fifo_empty,
  output logic [RATIO*DATA_WIDTH-1:0]   out_data,
  output logic                          out_valid,
  input  logic                          out_ready
`ifdef FIFO_WORD_PACKER_FLUSH_EN
  ,
  input  logic                          flush,
  output logic [$clog2(RATIO+1)-1:0]    out_count
`endif
);

  localparam int CW = count_width(RATIO);
  localparam int SW = CW + 1;
  localparam logic [CW-1:0] LAST_LANE = CW'(RATIO - 1);
  localparam logic [SW-1:0] RATIO_S   = SW'(RATIO);

  packer_state_t         r_state;
  logic [CW-1:0]         r_count;
  logic                  r_pending;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_lanes [RATIO];

  logic [SW-1:0]         w_sum;
  logic                  w_pop_ok;
  logic                  w_pop;
  logic                  w_cap;

  // Lanes already held plus the one still in flight from a registered-read pop.
  assign w_sum    = {1'b0, r_count} + {{CW{1'b0}}, r_pending};
  assign w_pop_ok = rst && (r_state == FILL) && !fifo_empty && (w_sum < RATIO_S);

`ifdef FIFO_WORD_PACKER_FLUSH_EN
  localparam int OW = $clog2(RATIO + 1);
  logic [OW-1:0] r_out_count;
  logic          w_flush_go;

  assign w_flush_go = flush && (r_state == FILL) && (r_count != '0) && !r_pending;
  // A flushing cycle moves straight to HOLD, so no new word may be popped on it.
  assign w_pop      = w_pop_ok && !w_flush_go;
  assign out_count  = r_out_count;
`else
  assign w_pop      = w_pop_ok;
`endif

  // Registered read: data arrives the cycle after the pop. Fall-through: same edge.
  assign w_cap     = (FALL_THROUGH != 0) ? w_pop : r_pending;
  assign fifo_en   = w_pop;
  assign fifo_rw   = 1'b0;
  assign out_valid = r_valid;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= FILL;
      r_count   <= '0;
      r_pending <= 1'b0;
      r_valid   <= 1'b0;
      for (int i = 0; i < RATIO; i++) r_lanes[i] <= '0;
`ifdef FIFO_WORD_PACKER_FLUSH_EN
      r_out_count <= '0;
`endif
    end else begin
      r_pending <= (FALL_THROUGH == 0) && w_pop;
      if (w_cap) begin
        r_lanes[r_count] <= fifo_out;
        if (r_count == LAST_LANE) begin
          r_count <= '0;
          r_state <= HOLD;
          r_valid <= 1'b1;
`ifdef FIFO_WORD_PACKER_FLUSH_EN
          r_out_count <= OW'(RATIO);
`endif
        end else begin
          r_count <= r_count + CW'(1);
        end
      end
`ifdef FIFO_WORD_PACKER_FLUSH_EN
      else if (w_flush_go) begin
        r_count     <= '0;
        r_state     <= HOLD;
        r_valid     <= 1'b1;
        r_out_count <= OW'(r_count);
      end
`endif
      if ((r_state == HOLD) && r_valid && out_ready) begin
        r_valid <= 1'b0;
        r_state <= FILL;
      end
    end
  end

  // Lanes beyond the valid count of a flushed word read as zero.
  always_comb begin
    out_data = '0;
    for (int i = 0; i < RATIO; i++) begin
`ifdef FIFO_WORD_PACKER_FLUSH_EN
      if (OW'(i) < r_out_count)
`endif
        out_data[i*DATA_WIDTH +: DATA_WIDTH] = r_lanes[i];
    end
  end

endmodule

// File: tb/tb_fifo_word_packer.sv
// tb/tb_fifo_word_packer.sv - self-checking bench for fifo_word_packer, both FIFO read modes

module tb_fifo_word_packer;

  localparam int DW = 4;
  localparam int R  = 4;
  localparam int OW = DW * R;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b0;
  logic out_ready = 1'b0;
  logic en0, rw0, v0, en1, rw1, v1;
  logic [OW-1:0] d0, d1;
  logic [DW-1:0] f0_data = '0;
  logic [DW-1:0] f1_data = '0;
  logic f0_empty = 1'b1;
  logic f1_empty = 1'b1;
  logic push_req = 1'b0;
  logic [DW-1:0] push_val = '0;
`ifdef FIFO_WORD_PACKER_FLUSH_EN
  logic flush = 1'b0;
  logic [2:0] oc0, oc1;
`endif

  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  logic [OW-1:0] exp0[$];
  logic [OW-1:0] exp1[$];
  logic [OW-1:0] pk = '0;
  int n = 0;
  int total = 0;
  int bad = 0;
  int en0_cnt = 0;
  int en1_cnt = 0;
  int en_bad = 0;

  fifo_word_packer #(.DATA_WIDTH(DW), .RATIO(R), .FALL_THROUGH(0)) u_dut0 (
    .clk(clk), .rst(rst), .fifo_en(en0), .fifo_rw(rw0), .fifo_out(f0_data),
    .fifo_empty(f0_empty), .out_data(d0), .out_valid(v0), .out_ready(out_ready)
`ifdef FIFO_WORD_PACKER_FLUSH_EN
    , .flush(flush), .out_count(oc0)
`endif
  );

  fifo_word_packer #(.DATA_WIDTH(DW), .RATIO(R), .FALL_THROUGH(1)) u_dut1 (
    .clk(clk), .rst(rst), .fifo_en(en1), .fifo_rw(rw1), .fifo_out(f1_data),
    .fifo_empty(f1_empty), .out_data(d1), .out_valid(v1), .out_ready(out_ready)
`ifdef FIFO_WORD_PACKER_FLUSH_EN
    , .flush(flush), .out_count(oc1)
`endif
  );

  // Upstream FIFOs: q0 has registered read data, q1 presents its head word.
  always @(posedge clk) begin
    if (!rst) begin
      q0.delete();
      q1.delete();
      f0_data <= '0;
    end else begin
      if (en0 && q0.size() != 0) f0_data <= q0.pop_front();
      if (en1 && q1.size() != 0) void'(q1.pop_front());
      if (push_req) begin
        q0.push_back(push_val);
        q1.push_back(push_val);
      end
    end
    f0_empty <= (q0.size() == 0);
    f1_empty <= (q1.size() == 0);
    f1_data  <= (q1.size() != 0) ? q1[0] : '0;
  end

  // Pop counters, and pops attempted against an empty FIFO.
  always @(posedge clk) begin
    if (en0) en0_cnt++;
    if (en1) en1_cnt++;
    if ((en0 && f0_empty) || (en1 && f1_empty)) en_bad++;
  end

  task automatic push_word(input logic [DW-1:0] v);
    push_req = 1'b1;
    push_val = v;
    @(negedge clk);
    push_req = 1'b0;
    pk = {v, pk[OW-1:DW]};
    n++;
    if (n == R) begin
      exp0.push_back(pk);
      exp1.push_back(pk);
      n = 0;
    end
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b0;
    out_ready = 1'b0;
    repeat (cycles) @(negedge clk);
    rst = 1'b1;
    exp0.delete();
    exp1.delete();
    pk = '0;
    n = 0;
  endtask

  task automatic wait_both(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (v0 && v1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (v0 !== 1'b0) begin bad++; $display("FAIL reset_valid0 got=%b want=0", v0); end
    total++; if (v1 !== 1'b0) begin bad++; $display("FAIL reset_valid1 got=%b want=0", v1); end
    total++; if (d0 !== 16'h0000) begin bad++; $display("FAIL reset_data0 got=%h want=0000", d0); end
    total++; if (d1 !== 16'h0000) begin bad++; $display("FAIL reset_data1 got=%h want=0000", d1); end
    total++; if (en0 !== 1'b0 || en1 !== 1'b0) begin bad++; $display("FAIL reset_en got=%b%b want=00", en0, en1); end
    total++; if (rw0 !== 1'b0 || rw1 !== 1'b0) begin bad++; $display("FAIL reset_rw got=%b%b want=00", rw0, rw1); end
    rst = 1'b1;
  endtask

  task automatic test_pack_basic();
    int s0, s1;
    bit ok;
    logic [OW-1:0] e;
    out_ready = 1'b0;
    s0 = en0_cnt;
    s1 = en1_cnt;
    for (int i = 1; i <= 4; i++) push_word(DW'(i));
    wait_both(ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL basic_wait got=%b want=1", ok); end
    e = (exp0.size() != 0) ? exp0.pop_front() : 'x;
    total++; if (d0 !== e) begin bad++; $display("FAIL basic_data_ft0 got=%h want=%h", d0, e); end
    e = (exp1.size() != 0) ? exp1.pop_front() : 'x;
    total++; if (d1 !== e) begin bad++; $display("FAIL basic_data_ft1 got=%h want=%h", d1, e); end
    total++; if (d0 !== 16'h4321) begin bad++; $display("FAIL basic_literal got=%h want=4321", d0); end
    total++; if (en0_cnt - s0 !== 4) begin bad++; $display("FAIL basic_pops_ft0 got=%0d want=4", en0_cnt - s0); end
    total++; if (en1_cnt - s1 !== 4) begin bad++; $display("FAIL basic_pops_ft1 got=%0d want=4", en1_cnt - s1); end
`ifdef FIFO_WORD_PACKER_FLUSH_EN
    total++; if (oc0 !== 3'd4 || oc1 !== 3'd4) begin bad++; $display("FAIL basic_count got=%0d,%0d want=4", oc0, oc1); end
`endif
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    total++; if (v0 !== 1'b0 || v1 !== 1'b0) begin bad++; $display("FAIL basic_accept got=%b%b want=00", v0, v1); end
  endtask

  task automatic test_backpressure();
    int s0, s1;
    bit ok;
    logic [OW-1:0] e;
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push_word(DW'(i));
    wait_both(ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL bp_wait1 got=%b want=1", ok); end
    s0 = en0_cnt;
    s1 = en1_cnt;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      total++;
      if (v0 !== 1'b1 || v1 !== 1'b1 || d0 !== exp0[0] || d1 !== exp1[0]) begin
        bad++; $display("FAIL bp_hold cyc=%0d got=%h/%h v=%b%b want=%h", c, d0, d1, v0, v1, exp0[0]);
      end
    end
    total++; if ((en0_cnt - s0) + (en1_cnt - s1) !== 0) begin bad++; $display("FAIL bp_no_pops got=%0d want=0", (en0_cnt - s0) + (en1_cnt - s1)); end
    e = (exp0.size() != 0) ? exp0.pop_front() : 'x;
    total++; if (d0 !== e) begin bad++; $display("FAIL bp_word1_ft0 got=%h want=%h", d0, e); end
    e = (exp1.size() != 0) ? exp1.pop_front() : 'x;
    total++; if (d1 !== e) begin bad++; $display("FAIL bp_word1_ft1 got=%h want=%h", d1, e); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    wait_both(ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL bp_wait2 got=%b want=1", ok); end
    e = (exp0.size() != 0) ? exp0.pop_front() : 'x;
    total++; if (d0 !== e) begin bad++; $display("FAIL bp_word2_ft0 got=%h want=%h", d0, e); end
    e = (exp1.size() != 0) ? exp1.pop_front() : 'x;
    total++; if (d1 !== e) begin bad++; $display("FAIL bp_word2_ft1 got=%h want=%h", d1, e); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_empty_stall();
    int s0, s1;
    bit ok;
    logic [OW-1:0] e;
    out_ready = 1'b1;
    s0 = en0_cnt;
    s1 = en1_cnt;
    push_word(4'd1);
    push_word(4'd2);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++; if (v0 !== 1'b0 || v1 !== 1'b0) begin bad++; $display("FAIL stall_valid cyc=%0d got=%b%b want=00", c, v0, v1); end
    end
    total++; if (en0_cnt - s0 !== 2) begin bad++; $display("FAIL stall_pops_ft0 got=%0d want=2", en0_cnt - s0); end
    total++; if (en1_cnt - s1 !== 2) begin bad++; $display("FAIL stall_pops_ft1 got=%0d want=2", en1_cnt - s1); end
    out_ready = 1'b0;
    push_word(4'd3);
    push_word(4'd4);
    wait_both(ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL stall_wait got=%b want=1", ok); end
    e = (exp0.size() != 0) ? exp0.pop_front() : 'x;
    total++; if (d0 !== e) begin bad++; $display("FAIL stall_data_ft0 got=%h want=%h", d0, e); end
    e = (exp1.size() != 0) ? exp1.pop_front() : 'x;
    total++; if (d1 !== e) begin bad++; $display("FAIL stall_data_ft1 got=%h want=%h", d1, e); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [OW-1:0] e;
    out_ready = 1'b0;
    push_word(4'd7);
    push_word(4'd8);
    @(negedge clk);
    do_reset(1);
    for (int i = 1; i <= 4; i++) push_word(DW'(i));
    wait_both(ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL rmid_wait got=%b want=1", ok); end
    e = (exp0.size() != 0) ? exp0.pop_front() : 'x;
    total++; if (d0 !== e) begin bad++; $display("FAIL rmid_data_ft0 got=%h want=%h", d0, e); end
    e = (exp1.size() != 0) ? exp1.pop_front() : 'x;
    total++; if (d1 !== e) begin bad++; $display("FAIL rmid_data_ft1 got=%h want=%h", d1, e); end
    rst = 1'b0;
    @(negedge clk);
    total++; if (v0 !== 1'b0 || v1 !== 1'b0) begin bad++; $display("FAIL rhold_valid got=%b%b want=00", v0, v1); end
    do_reset(1);
  endtask

`ifdef FIFO_WORD_PACKER_FLUSH_EN
  task automatic test_flush();
    bit ok;
    logic [OW-1:0] e;
    out_ready = 1'b0;
    push_word(4'd5);
    push_word(4'd6);
    repeat (4) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    e = pk >> ((R - n) * DW);
    exp0.push_back(e);
    exp1.push_back(e);
    n = 0;
    wait_both(ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL flush_wait got=%b want=1", ok); end
    e = (exp0.size() != 0) ? exp0.pop_front() : 'x;
    total++; if (d0 !== e) begin bad++; $display("FAIL flush_data_ft0 got=%h want=%h", d0, e); end
    e = (exp1.size() != 0) ? exp1.pop_front() : 'x;
    total++; if (d1 !== e) begin bad++; $display("FAIL flush_data_ft1 got=%h want=%h", d1, e); end
    total++; if (oc0 !== 3'd2 || oc1 !== 3'd2) begin bad++; $display("FAIL flush_count got=%0d,%0d want=2", oc0, oc1); end
    rst = 1'b0;
    @(negedge clk);
    total++; if (v0 !== 1'b0 || v1 !== 1'b0) begin bad++; $display("FAIL flush_reset got=%b%b want=00", v0, v1); end
    do_reset(1);
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_pack_basic();
    test_backpressure();
    test_empty_stall();
    test_reset_mid();
`ifdef FIFO_WORD_PACKER_FLUSH_EN
    test_flush();
`endif
    repeat (2) @(negedge clk);
    total++; if (en_bad !== 0) begin bad++; $display("FAIL pop_when_empty got=%0d want=0", en_bad); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
